// File: rtl/wb_src_select_reg_if.sv
// wb_src_select_reg_if
//   Bundles the request side and the registered write-back side of the
//   write-back source selector.
//   master : control/datapath side; drives sources, selector, request, stall, clear.
//   slave  : selector block; drives wb_data/wb_addr/wb_we and the error flag.
//   Signals:
//     src_bus      packed sources, channel i = src_bus[i*DATA_W +: DATA_W]
//     seletor      source select code
//     req_valid    write-back request this cycle
//     dest_addr    destination register address
//     stall        freeze request from control unit
//     err_clr      clears the sticky error
//     wb_data      registered selected data
//     wb_addr      registered destination address
//     wb_we        one-cycle register-file write strobe
//     bad_sel      sticky illegal-selector flag
//     bad_sel_code first illegal selector since the last clear
interface wb_src_select_reg_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 11,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned ADDR_W  = 5
);
  logic [NUM_SRC*DATA_W-1:0] src_bus;
  logic [SEL_W-1:0]          seletor;
  logic                      req_valid;
  logic [ADDR_W-1:0]         dest_addr;
  logic                      stall;
  logic                      err_clr;
  logic [DATA_W-1:0]         wb_data;
  logic [ADDR_W-1:0]         wb_addr;
  logic                      wb_we;
  logic                      bad_sel;
  logic [SEL_W-1:0]          bad_sel_code;

  modport master (
    output src_bus, seletor, req_valid, dest_addr, stall, err_clr,
    input  wb_data, wb_addr, wb_we, bad_sel, bad_sel_code
  );

  modport slave (
    input  src_bus, seletor, req_valid, dest_addr, stall, err_clr,
    output wb_data, wb_addr, wb_we, bad_sel, bad_sel_code
  );
endinterface

// File: rtl/wb_src_select_reg.sv
// wb_src_select_reg
//   Registered write-back source selector. Picks one of NUM_SRC source
//   channels, or the constant CONST_VAL when the selector equals CONST_SEL,
//   and registers it with the destination address. An accepted request
//   (req_valid & ~stall) with a legal code produces wb_we=1 for exactly one
//   cycle, one clock later. Illegal codes raise a sticky bad_sel flag that
//   keeps the first offending code until err_clr.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    wb_src_select_reg_if.slave (request in, write-back out)
//   All outputs come straight from flops.
module wb_src_select_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_SRC   = 11,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned CONST_SEL = 8,
  parameter int unsigned CONST_VAL = 227,
  parameter int unsigned ADDR_W    = 5
) (
  input logic                clk,
  input logic                reset,
  wb_src_select_reg_if.slave bus
);

  // Extra bit so NUM_SRC == 2**SEL_W still fits for the range compare.
  localparam logic [SEL_W:0]    NumSrcExt    = (SEL_W + 1)'(NUM_SRC);
  // A CONST_SEL outside the selector range can never match; without this
  // guard the truncated code would alias onto a real channel.
  localparam bit                ConstInRange = (CONST_SEL < (2 ** SEL_W));
  localparam logic [SEL_W-1:0]  ConstSelCode = SEL_W'(CONST_SEL);
  localparam logic [DATA_W-1:0] ConstData    = DATA_W'(CONST_VAL);

  logic [DATA_W-1:0] chan [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_chan
    assign chan[g] = bus.src_bus[g*DATA_W +: DATA_W];
  end

  logic              sel_is_const;
  logic              sel_in_range;
  logic              sel_legal;
  logic [DATA_W-1:0] chan_data;
  logic [DATA_W-1:0] sel_data;
  logic              accept;
  logic              wr_ok;
  logic              trap;

  always_comb begin
    sel_is_const = ConstInRange && (bus.seletor == ConstSelCode);
    sel_in_range = ({1'b0, bus.seletor} < NumSrcExt);
    sel_legal    = sel_is_const | sel_in_range;

    // Explicit compare mux keeps out-of-range codes from indexing past chan.
    chan_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if ({1'b0, bus.seletor} == (SEL_W + 1)'(i)) begin
        chan_data = chan[i];
      end
    end

    // The constant shadows its channel when CONST_SEL < NUM_SRC.
    sel_data = sel_is_const ? ConstData : chan_data;

    accept = bus.req_valid & ~bus.stall;
    wr_ok  = accept & sel_legal;
    trap   = accept & ~sel_legal;
  end

  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic              wb_we_q, wb_we_d;
  logic              bad_sel_q, bad_sel_d;
  logic [SEL_W-1:0]  bad_code_q, bad_code_d;

  always_comb begin
    wb_data_d  = wb_data_q;
    wb_addr_d  = wb_addr_q;
    wb_we_d    = wr_ok;
    bad_sel_d  = bad_sel_q;
    bad_code_d = bad_code_q;

    if (wr_ok) begin
      wb_data_d = sel_data;
      wb_addr_d = bus.dest_addr;
    end

    if (bus.err_clr) begin
      bad_sel_d  = 1'b0;
      bad_code_d = '0;
    end

    // A new trap beats a same-cycle clear; otherwise the first code sticks.
    if (trap) begin
      bad_sel_d = 1'b1;
      if (!bad_sel_q || bus.err_clr) begin
        bad_code_d = bus.seletor;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data_q  <= '0;
      wb_addr_q  <= '0;
      wb_we_q    <= 1'b0;
      bad_sel_q  <= 1'b0;
      bad_code_q <= '0;
    end else begin
      wb_data_q  <= wb_data_d;
      wb_addr_q  <= wb_addr_d;
      wb_we_q    <= wb_we_d;
      bad_sel_q  <= bad_sel_d;
      bad_code_q <= bad_code_d;
    end
  end

  assign bus.wb_data      = wb_data_q;
  assign bus.wb_addr      = wb_addr_q;
  assign bus.wb_we        = wb_we_q;
  assign bus.bad_sel      = bad_sel_q;
  assign bus.bad_sel_code = bad_code_q;

endmodule

// File: tb/tb_wb_src_select_reg.sv
// Bench for wb_src_select_reg: default instance (unit 0) and a narrow
// variant (unit 1: DATA_W=16, NUM_SRC=4, CONST_SEL=5, CONST_VAL=16'h00E3).
module tb_wb_src_select_reg;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  wb_src_select_reg_if #(.DATA_W(32), .NUM_SRC(11), .SEL_W(4), .ADDR_W(5)) bus_a ();
  wb_src_select_reg_if #(.DATA_W(16), .NUM_SRC(4), .SEL_W(4), .ADDR_W(5)) bus_b ();

  wb_src_select_reg #(
    .DATA_W(32), .NUM_SRC(11), .SEL_W(4), .CONST_SEL(8), .CONST_VAL(227), .ADDR_W(5)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  wb_src_select_reg #(
    .DATA_W(16), .NUM_SRC(4), .SEL_W(4), .CONST_SEL(5), .CONST_VAL(32'h00E3), .ADDR_W(5)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  typedef struct {
    string       name;
    bit          unit;
    bit          rst;
    bit          rv;
    bit          st;
    bit          clr;
    logic [3:0]  sel;
    logic [4:0]  addr;
    logic [31:0] e_data;
    logic [4:0]  e_addr;
    bit          e_we;
    bit          e_bad;
    logic [3:0]  e_code;
  } vec_t;

  typedef struct {
    string       name;
    bit          unit;
    logic [42:0] exp;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  function automatic vec_t mk(string n, bit unit, bit rst, bit rv, bit st, bit clr,
                              logic [3:0] sel, logic [4:0] addr, logic [31:0] d,
                              logic [4:0] a, bit we, bit bad, logic [3:0] code);
    vec_t v;
    v.name = n; v.unit = unit; v.rst = rst; v.rv = rv; v.st = st; v.clr = clr;
    v.sel = sel; v.addr = addr; v.e_data = d; v.e_addr = a; v.e_we = we;
    v.e_bad = bad; v.e_code = code;
    return v;
  endfunction

  // Drive one cycle, record the expectation, then compare after the edge.
  task automatic apply(input vec_t v);
    exp_t        e;
    exp_t        p;
    logic [42:0] got;
    if (v.unit == 1'b0) begin
      rst_a = v.rst;
      bus_a.req_valid = v.rv; bus_a.stall = v.st; bus_a.err_clr = v.clr;
      bus_a.seletor = v.sel; bus_a.dest_addr = v.addr;
      bus_b.req_valid = 1'b0; bus_b.stall = 1'b0; bus_b.err_clr = 1'b0;
    end else begin
      rst_b = v.rst;
      bus_b.req_valid = v.rv; bus_b.stall = v.st; bus_b.err_clr = v.clr;
      bus_b.seletor = v.sel; bus_b.dest_addr = v.addr;
      bus_a.req_valid = 1'b0; bus_a.stall = 1'b0; bus_a.err_clr = 1'b0;
    end
    e.name = v.name;
    e.unit = v.unit;
    e.exp  = {v.e_data, v.e_addr, v.e_we, v.e_bad, v.e_code};
    sb.push_back(e);
    @(posedge clk);
    #1;
    p = sb.pop_front();
    if (p.unit == 1'b0) begin
      got = {bus_a.wb_data, bus_a.wb_addr, bus_a.wb_we, bus_a.bad_sel, bus_a.bad_sel_code};
    end else begin
      got = {16'h0, bus_b.wb_data, bus_b.wb_addr, bus_b.wb_we, bus_b.bad_sel,
             bus_b.bad_sel_code};
    end
    checks++;
    if (got !== p.exp) begin
      errors++;
      $display("FAIL %s(u%0d): got data=%h addr=%0d we=%b bad=%b code=%0d, exp data=%h addr=%0d we=%b bad=%b code=%0d",
               p.name, p.unit, got[42:11], got[10:6], got[5], got[4], got[3:0],
               p.exp[42:11], p.exp[10:6], p.exp[5], p.exp[4], p.exp[3:0]);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.stall = 1'b0; bus_a.err_clr = 1'b0;
    bus_a.seletor = '0; bus_a.dest_addr = '0;
    bus_b.req_valid = 1'b0; bus_b.stall = 1'b0; bus_b.err_clr = 1'b0;
    bus_b.seletor = '0; bus_b.dest_addr = '0;
    for (int i = 0; i < 11; i++) bus_a.src_bus[i*32 +: 32] = 32'h1000_0000 + i;
    for (int i = 0; i < 4; i++) bus_b.src_bus[i*16 +: 16] = 16'hA000 + 16'(i);

    // ---- table: reset, legal sweep, illegal/clear ----
    for (int i = 0; i < 2; i++) begin
      vecs.push_back(mk("reset", 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 4'($urandom), 5'($urandom),
                        32'h0, 5'd0, 0, 0, 4'd0));
    end
    vecs.push_back(mk("idle_after_reset", 0, 0, 0, 0, 0, 4'd0, 5'd0, 32'h0, 5'd0, 0, 0, 4'd0));
    for (int i = 0; i < 11; i++) begin
      vecs.push_back(mk("sweep", 0, 0, 1, 0, 0, 4'(i), 5'(i + 1),
                        (i == 8) ? 32'd227 : 32'h1000_0000 + i, 5'(i + 1), 1, 0, 4'd0));
    end
    vecs.push_back(mk("illegal13", 0, 0, 1, 0, 0, 4'd13, 5'd20, 32'h1000_000A, 5'd11, 0, 1, 4'd13));
    vecs.push_back(mk("illegal15_keeps13", 0, 0, 1, 0, 0, 4'd15, 5'd21, 32'h1000_000A, 5'd11,
                      0, 1, 4'd13));
    vecs.push_back(mk("clr_alone", 0, 0, 0, 0, 1, 4'd0, 5'd0, 32'h1000_000A, 5'd11, 0, 0, 4'd0));
    vecs.push_back(mk("clr_with_illegal12", 0, 0, 1, 0, 1, 4'd12, 5'd22, 32'h1000_000A, 5'd11,
                      0, 1, 4'd12));
    vecs.push_back(mk("clr_again", 0, 0, 0, 0, 1, 4'd0, 5'd0, 32'h1000_000A, 5'd11, 0, 0, 4'd0));
    vecs.push_back(mk("addr_zero", 0, 0, 1, 0, 0, 4'd7, 5'd0, 32'h1000_0007, 5'd0, 1, 0, 4'd0));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // ---- stall: frozen illegal ignored, then held legal request ----
    bus_a.src_bus[2*32 +: 32] = 32'hDEAD_BEEF;
    apply(mk("stall_illegal", 0, 0, 1, 1, 0, 4'd14, 5'd1, 32'h1000_0007, 5'd0, 0, 0, 4'd0));
    for (int i = 0; i < 3; i++) begin
      apply(mk("stall_hold", 0, 0, 1, 1, 0, 4'd2, 5'd3, 32'h1000_0007, 5'd0, 0, 0, 4'd0));
    end
    apply(mk("stall_release", 0, 0, 1, 0, 0, 4'd2, 5'd3, 32'hDEAD_BEEF, 5'd3, 1, 0, 4'd0));
    apply(mk("stall_single_we", 0, 0, 0, 0, 0, 4'd2, 5'd3, 32'hDEAD_BEEF, 5'd3, 0, 0, 4'd0));

    // ---- back-to-back ----
    apply(mk("b2b_0", 0, 0, 1, 0, 0, 4'd0, 5'd5, 32'h1000_0000, 5'd5, 1, 0, 4'd0));
    apply(mk("b2b_1", 0, 0, 1, 0, 0, 4'd1, 5'd6, 32'h1000_0001, 5'd6, 1, 0, 4'd0));
    apply(mk("b2b_3", 0, 0, 1, 0, 0, 4'd3, 5'd7, 32'h1000_0003, 5'd7, 1, 0, 4'd0));
    apply(mk("b2b_drop", 0, 0, 0, 0, 0, 4'd3, 5'd7, 32'h1000_0003, 5'd7, 0, 0, 4'd0));

    // ---- reset mid-stream with we=1 and bad_sel=1 ----
    apply(mk("mid_illegal14", 0, 0, 1, 0, 0, 4'd14, 5'd1, 32'h1000_0003, 5'd7, 0, 1, 4'd14));
    apply(mk("mid_legal4", 0, 0, 1, 0, 0, 4'd4, 5'd9, 32'h1000_0004, 5'd9, 1, 1, 4'd14));
    apply(mk("mid_reset", 0, 1, 1, 0, 0, 4'd5, 5'd9, 32'h0, 5'd0, 0, 0, 4'd0));
    apply(mk("mid_resume", 0, 0, 1, 0, 0, 4'd6, 5'd10, 32'h1000_0006, 5'd10, 1, 0, 4'd0));

    // ---- parameter variant ----
    apply(mk("var_reset", 1, 1, 1, 0, 0, 4'd5, 5'd2, 32'h0, 5'd0, 0, 0, 4'd0));
    apply(mk("var_const5", 1, 0, 1, 0, 0, 4'd5, 5'd2, 32'h0000_00E3, 5'd2, 1, 0, 4'd0));
    apply(mk("var_illegal4", 1, 0, 1, 0, 0, 4'd4, 5'd3, 32'h0000_00E3, 5'd2, 0, 1, 4'd4));
    apply(mk("var_chan3", 1, 0, 1, 0, 0, 4'd3, 5'd4, 32'h0000_A003, 5'd4, 1, 1, 4'd4));
    apply(mk("var_illegal9", 1, 0, 1, 0, 0, 4'd9, 5'd6, 32'h0000_A003, 5'd4, 0, 1, 4'd4));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
